multimode_register: RTL and testbench

//  Parametrised successor to the single-bit D flip-flop with preset/clear: a WIDTH-bit

---
 rtl/multimode_register.sv | 147 ++++++++++++++
 tb/tb_multimode_register.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multimode_register.sv
// WIDTH-bit register with hold, shift, rotate, parallel load and up/down count modes.
// Async active-low clear, synchronous preset, complementary outputs and serial tap.
module multimode_register #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] CLEAR_VALUE  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             input_clk,
  input  logic             input_clear_n,
  input  logic             input_preset,
  input  logic             input_enable,
  input  logic [2:0]       input_mode,
  input  logic [WIDTH-1:0] input_data,
  input  logic             input_serial_msb,
  input  logic             input_serial_lsb,
  output logic [WIDTH-1:0] output_q,
  output logic [WIDTH-1:0] output_q_n,
  output logic             output_serial_out,
  output logic             output_terminal
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_UP   = 3'b110;
  localparam logic [2:0] MODE_DOWN = 3'b111;

  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};

  logic [WIDTH-1:0] q_d, q_q;
  logic             serial_d, serial_q;

  // Next-state selection: preset overrides enable, enable=0 holds everything.
  always_comb begin
    q_d      = q_q;
    serial_d = serial_q;
    if (input_preset) begin
      q_d      = PRESET_VALUE;
      serial_d = 1'b0;
    end else if (input_enable) begin
      case (input_mode)
        MODE_HOLD: begin
          q_d = q_q;
        end
        MODE_SHR: begin
          q_d      = {input_serial_msb, q_q[WIDTH-1:1]};
          serial_d = q_q[0];
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], input_serial_lsb};
          serial_d = q_q[WIDTH-1];
        end
        MODE_LOAD: begin
          q_d = input_data;
        end
        MODE_ROR: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          serial_d = q_q[0];
        end
        MODE_ROL: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          serial_d = q_q[WIDTH-1];
        end
        MODE_UP: begin
          q_d = q_q + ONE;
        end
        MODE_DOWN: begin
          q_d = q_q - ONE;
        end
        default: begin
          q_d      = q_q;
          serial_d = serial_q;
        end
      endcase
    end else begin
      q_d      = q_q;
      serial_d = serial_q;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge input_clk or negedge input_clear_n) begin
    if (!input_clear_n) begin
      q_q      <= CLEAR_VALUE;
      serial_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      serial_q <= serial_d;
    end
  end

  // Terminal count flag: only meaningful while a count mode is actually applied.
  always_comb begin
    output_terminal = 1'b0;
    if (input_clear_n && !input_preset && input_enable) begin
      if (input_mode == MODE_UP) begin
        output_terminal = (q_q == ALL_ONES);
      end else if (input_mode == MODE_DOWN) begin
        output_terminal = (q_q == ALL_ZEROS);
      end else begin
        output_terminal = 1'b0;
      end
    end else begin
      output_terminal = 1'b0;
    end
  end

  assign output_q          = q_q;
  assign output_q_n        = ~q_q;
  assign output_serial_out = serial_q;

  multimode_register_chk #(.WIDTH(WIDTH)) u_chk (
    .clk     (input_clk),
    .clear_n (input_clear_n),
    .preset  (input_preset),
    .enable  (input_enable),
    .mode    (input_mode),
    .q       (output_q),
    .q_n     (output_q_n)
  );

endmodule

// Protocol checker: mode must be known whenever it is applied, and q_n mirrors q.
module multimode_register_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             clear_n,
  input logic             preset,
  input logic             enable,
  input logic [2:0]       mode,
  input logic [WIDTH-1:0] q,
  input logic [WIDTH-1:0] q_n
);

  a_mode_known: assert property (@(posedge clk) disable iff (!clear_n)
    (enable && !preset) |-> !$isunknown(mode));

  a_q_n_complement: assert property (@(posedge clk) q_n == ~q);

endmodule

// File: tb/tb_multimode_register.sv
// Self-checking bench for multimode_register (WIDTH=8): directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_multimode_register;

  logic       clk = 1'b0;
  logic       clear_n, preset, enable, msb, lsb;
  logic [2:0] mode;
  logic [7:0] data;
  logic [7:0] q, q_n;
  logic       so, term;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_q;
  logic       m_so;

  multimode_register #(.WIDTH(8)) dut (
    .input_clk         (clk),
    .input_clear_n     (clear_n),
    .input_preset      (preset),
    .input_enable      (enable),
    .input_mode        (mode),
    .input_data        (data),
    .input_serial_msb  (msb),
    .input_serial_lsb  (lsb),
    .output_q          (q),
    .output_q_n        (q_n),
    .output_serial_out (so),
    .output_terminal   (term)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic pre, input logic [2:0] md,
                       input logic [7:0] d, input logic sm, input logic sl);
    enable = en; preset = pre; mode = md; data = d; msb = sm; lsb = sl;
  endtask

  // Reference model: applies the mode rules with plain arithmetic, then advances one edge.
  task automatic step();
    logic [7:0] nq;
    logic       ns;
    nq = m_q; ns = m_so;
    if (!clear_n) begin
      nq = 8'd0; ns = 1'b0;
    end else if (preset) begin
      nq = 8'd255; ns = 1'b0;
    end else if (enable) begin
      case (mode)
        3'd1: begin nq = (m_q / 8'd2) + (msb ? 8'd128 : 8'd0); ns = m_q[0]; end
        3'd2: begin nq = (m_q * 8'd2) + {7'd0, lsb};           ns = m_q[7]; end
        3'd3: nq = data;
        3'd4: begin nq = (m_q / 8'd2) + (m_q[0] ? 8'd128 : 8'd0); ns = m_q[0]; end
        3'd5: begin nq = (m_q * 8'd2) + {7'd0, m_q[7]};           ns = m_q[7]; end
        3'd6: nq = m_q + 8'd1;
        3'd7: nq = m_q + 8'd255;
        default: nq = m_q;
      endcase
    end
    @(posedge clk); #1;
    m_q = nq; m_so = ns;
  endtask

  function automatic logic exp_term();
    return clear_n && !preset && enable &&
           ((mode == 3'd6 && m_q == 8'd255) || (mode == 3'd7 && m_q == 8'd0));
  endfunction

  task automatic test_reset();
    clear_n = 1'b0;
    drive(1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0);
    m_q = 8'h00; m_so = 1'b0;
    @(posedge clk); #1;
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
    checks++; if (q_n !== 8'hFF) begin failures++; $display("FAIL reset_q_n got=%h exp=FF", q_n); end
    checks++; if (so !== 1'b0) begin failures++; $display("FAIL reset_so got=%b exp=0", so); end
    checks++; if (term !== 1'b0) begin failures++; $display("FAIL reset_term got=%b exp=0", term); end
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    clear_n = 1'b1;
    step();
  endtask

  task automatic test_async_clear();
    drive(1'b1, 1'b0, 3'd3, 8'hA5, 1'b0, 1'b0);
    step();
    checks++; if (q !== 8'hA5) begin failures++; $display("FAIL load_a5 got=%h exp=a5", q); end
    #2 clear_n = 1'b0;
    #1;
    m_q = 8'h00; m_so = 1'b0;
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL async_clear_q got=%h exp=00", q); end
    checks++; if (q_n !== 8'hFF) begin failures++; $display("FAIL async_clear_q_n got=%h exp=ff", q_n); end
    drive(1'b0, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
    #1 clear_n = 1'b1;
    step();
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL post_clear_q got=%h exp=00", q); end
  endtask

  task automatic test_shift();
    logic exp_so [3] = '{1'b0, 1'b1, 1'b1};
    drive(1'b1, 1'b0, 3'd3, 8'h96, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0);
      step();
      checks++;
      if (so !== exp_so[i]) begin failures++; $display("FAIL shr_so[%0d] got=%b exp=%b", i, so, exp_so[i]); end
    end
    checks++; if (q !== 8'hF2) begin failures++; $display("FAIL shr_q got=%h exp=f2", q); end
    drive(1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 1'b1);
    step();
    checks++; if (q !== 8'hE5 || so !== 1'b1) begin failures++; $display("FAIL shl got=%h/%b exp=e5/1", q, so); end
  endtask

  task automatic test_rotate();
    drive(1'b1, 1'b0, 3'd3, 8'h81, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0);
    step();
    checks++; if (q !== 8'h03 || so !== 1'b1) begin failures++; $display("FAIL rol got=%h/%b exp=03/1", q, so); end
    drive(1'b1, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0);
    step(); step();
    checks++; if (q !== 8'hC0) begin failures++; $display("FAIL ror got=%h exp=c0", q); end
  endtask

  task automatic test_count();
    drive(1'b1, 1'b0, 3'd3, 8'hFE, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
    #1;
    checks++; if (term !== 1'b0) begin failures++; $display("FAIL term_fe got=%b exp=0", term); end
    step();
    checks++; if (q !== 8'hFF || term !== 1'b1) begin failures++; $display("FAIL up_ff got=%h/%b exp=ff/1", q, term); end
    step();
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL up_wrap got=%h exp=00", q); end
    drive(1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0);
    #1;
    checks++; if (term !== 1'b1) begin failures++; $display("FAIL term_down got=%b exp=1", term); end
    step();
    checks++; if (q !== 8'hFF) begin failures++; $display("FAIL down_wrap got=%h exp=ff", q); end
  endtask

  task automatic test_preset();
    drive(1'b1, 1'b0, 3'd3, 8'h3C, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    #1;
    checks++; if (term !== 1'b0) begin failures++; $display("FAIL preset_term got=%b exp=0", term); end
    step();
    checks++; if (q !== 8'hFF || so !== 1'b0) begin failures++; $display("FAIL preset got=%h/%b exp=ff/0", q, so); end
    drive(1'b0, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
    #1;
    checks++; if (term !== 1'b0) begin failures++; $display("FAIL hold_term got=%b exp=0", term); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (q !== 8'hFF) begin failures++; $display("FAIL hold[%0d] got=%h exp=ff", i, q); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0, 3'($urandom_range(0, 7)),
            8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        #2 clear_n = 1'b0;
        #1;
        m_q = 8'h00; m_so = 1'b0;
        checks++; if (q !== 8'h00 || so !== 1'b0) begin failures++; $display("FAIL rnd_clear[%0d] got=%h/%b exp=00/0", i, q, so); end
        #1 clear_n = 1'b1;
      end
      #1;
      checks++; if (term !== exp_term()) begin failures++; $display("FAIL rnd_term[%0d] got=%b exp=%b", i, term, exp_term()); end
      step();
      checks++; if (q !== m_q) begin failures++; $display("FAIL rnd_q[%0d] got=%h exp=%h", i, q, m_q); end
      checks++; if (q_n !== ~m_q) begin failures++; $display("FAIL rnd_q_n[%0d] got=%h exp=%h", i, q_n, ~m_q); end
      checks++; if (so !== m_so) begin failures++; $display("FAIL rnd_so[%0d] got=%b exp=%b", i, so, m_so); end
    end
  endtask

  initial begin
    test_reset();
    test_async_clear();
    test_shift();
    test_rotate();
    test_count();
    test_preset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
